// File: rtl/keypad_scan_ctrl_if.sv
// Key FIFO handshake: producer drives valid/code, consumer drives ready.
interface keypad_scan_ctrl_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;

    modport master (
        output key_valid,
        output key_code,
        input  key_ready
    );

    modport slave (
        input  key_valid,
        input  key_code,
        output key_ready
    );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x3 keypad scanner: row sequencing, column sync/debounce, key lock
// and a first-word fall-through FIFO of accepted BCD key codes.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV   = 8192,
    parameter int DEB_TICKS  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         column,
    output logic [2:0]         sel,
    input  logic               clr_ovf,
    output logic               busy,
    output logic               overflow,
    keypad_scan_ctrl_if.master kbus
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEB_TICKS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEB,
        S_HELD,
        S_REL
    } state_t;

    logic [2:0]    col_m_q;
    logic [2:0]    col_s_q;
    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic          tick;

    state_t        state_q;
    logic [1:0]    sel_q;
    logic [3:0]    cand_code_q;
    logic [2:0]    cand_col_q;
    logic [CW-1:0] deb_cnt_q;
    logic [CW-1:0] rel_cnt_q;

    logic          dec_valid;
    logic [1:0]    dec_pos;
    logic [3:0]    dec_code;
    logic          col_match;
    logic          col_idle;
    logic          deb_last;
    logic          rel_last;
    logic          push;

    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [NW-1:0] cnt_q;
    logic [NW-1:0] cnt_d;
    logic          ovf_q;
    logic          ovf_d;
    logic          full;
    logic          pop;
    logic          wr_en;

    // Columns are asynchronous to clk; only col_s_q is ever decoded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_m_q <= 3'b111;
            col_s_q <= 3'b111;
        end else begin
            col_m_q <= column;
            col_s_q <= col_m_q;
        end
    end

    assign tick = (div_q == DW'(SCAN_DIV - 1));

    always_comb begin
        div_d = div_q + DW'(1);
        if (tick) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Row 3 carries only the centre key (0); its side keys are blanks.
    always_comb begin
        dec_valid = 1'b0;
        dec_pos   = 2'd0;
        case (col_s_q)
            3'b011: begin
                dec_valid = (sel_q != 2'd3);
                dec_pos   = 2'd1;
            end
            3'b101: begin
                dec_valid = 1'b1;
                dec_pos   = 2'd2;
            end
            3'b110: begin
                dec_valid = (sel_q != 2'd3);
                dec_pos   = 2'd3;
            end
            default: begin
                dec_valid = 1'b0;
                dec_pos   = 2'd0;
            end
        endcase
        dec_code = ({2'b00, sel_q} * 4'd3) + {2'b00, dec_pos};
        if (sel_q == 2'd3) begin
            dec_code = 4'd0;
        end
    end

    assign col_match = (col_s_q == cand_col_q);
    assign col_idle  = (col_s_q == 3'b111);
    assign deb_last  = (deb_cnt_q == CW'(DEB_TICKS - 1));
    assign rel_last  = (rel_cnt_q == CW'(DEB_TICKS - 1));
    assign push      = tick && (state_q == S_DEB) && col_match && deb_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_SCAN;
            sel_q       <= 2'd0;
            cand_code_q <= 4'd0;
            cand_col_q  <= 3'b111;
            deb_cnt_q   <= '0;
            rel_cnt_q   <= '0;
        end else if (tick) begin
            unique case (state_q)
                S_SCAN: begin
                    if (dec_valid) begin
                        cand_code_q <= dec_code;
                        cand_col_q  <= col_s_q;
                        deb_cnt_q   <= CW'(1);
                        state_q     <= S_DEB;
                    end else begin
                        sel_q <= sel_q + 2'd1;
                    end
                end
                S_DEB: begin
                    if (col_match) begin
                        deb_cnt_q <= deb_cnt_q + CW'(1);
                        if (deb_last) begin
                            state_q <= S_HELD;
                        end
                    end else begin
                        state_q <= S_SCAN;
                        sel_q   <= sel_q + 2'd1;
                    end
                end
                S_HELD: begin
                    if (col_idle) begin
                        rel_cnt_q <= CW'(1);
                        state_q   <= S_REL;
                    end
                end
                S_REL: begin
                    if (col_idle) begin
                        rel_cnt_q <= rel_cnt_q + CW'(1);
                        if (rel_last) begin
                            state_q <= S_SCAN;
                            sel_q   <= sel_q + 2'd1;
                        end
                    end else begin
                        state_q <= S_HELD;
                    end
                end
                default: begin
                    state_q <= S_SCAN;
                end
            endcase
        end
    end

    assign full  = (cnt_q == NW'(FIFO_DEPTH));
    assign pop   = kbus.key_valid && kbus.key_ready;
    // A pop frees the slot the push lands in, so full+pop still accepts.
    assign wr_en = push && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + NW'(1);
            2'b01:   cnt_d = cnt_q - NW'(1);
            default: cnt_d = cnt_q;
        endcase
        ovf_d = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (push && full && !pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 4'd0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= cand_code_q;
        end
    end

    assign kbus.key_valid = (cnt_q != '0);
    assign kbus.key_code  = kbus.key_valid ? mem_q[rd_ptr_q] : 4'hF;
    assign sel            = {1'b0, sel_q};
    assign busy           = (state_q != S_SCAN);
    assign overflow       = ovf_q;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Randomized and directed bench for keypad_scan_ctrl against a
// tick-level behavioural model with a queue-based key FIFO.
module tb_keypad_scan_ctrl;
    localparam int DIV   = 4;
    localparam int DEB   = 3;
    localparam int DEPTH = 4;

    logic        clk     = 1'b0;
    logic        reset   = 1'b0;
    logic [2:0]  column  = 3'b111;
    logic [2:0]  sel;
    logic        clr_ovf = 1'b0;
    logic        busy;
    logic        overflow;

    keypad_scan_ctrl_if kif ();

    keypad_scan_ctrl #(
        .SCAN_DIV  (DIV),
        .DEB_TICKS (DEB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .column  (column),
        .sel     (sel),
        .clr_ovf (clr_ovf),
        .busy    (busy),
        .overflow(overflow),
        .kbus    (kif.master)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Physical keypad: 12 switch positions, row r / column c at r*3+c.
    logic [11:0] keys    = '0;
    logic        raw_en  = 1'b0;
    logic [2:0]  raw_col = 3'b111;

    function automatic logic [2:0] pad(input logic [2:0] s, input logic [11:0] k);
        logic [2:0] c;
        int r;
        c = 3'b111;
        r = int'(s);
        if (r < 4) begin
            for (int i = 0; i < 3; i++) begin
                if (k[r * 3 + i]) c[2 - i] = 1'b0;
            end
        end
        return c;
    endfunction

    // Reference model, advanced once per clock edge.
    int m_div = 0, m_row = 0, m_mode = 0, m_key = 0, m_pat = 7, m_n = 0;
    int m_s1 = 7, m_s2 = 7;
    int m_q[$];
    int m_ovf = 0;
    int t_k;
    bit t_pop, t_push, t_tick, t_set;

    function automatic int lookup(input int row, input int pat);
        int pos;
        pos = (pat == 3) ? 0 : (pat == 5) ? 1 : (pat == 6) ? 2 : -1;
        if (pos < 0) return -1;
        if (row == 3) return (pos == 1) ? 0 : -1;
        return row * 3 + pos + 1;
    endfunction

    function automatic bit push_next();
        return (m_div == DIV - 1) && (m_mode == 1) && (m_s2 == m_pat) && (m_n == DEB - 1);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_div = 0; m_row = 0; m_mode = 0; m_n = 0; m_key = 0; m_pat = 7;
            m_s1 = 7; m_s2 = 7; m_ovf = 0;
            m_q.delete();
        end else begin
            t_pop  = (m_q.size() > 0) && kif.key_ready;
            t_tick = (m_div == DIV - 1);
            t_push = 1'b0;
            t_set  = 1'b0;
            if (t_tick) begin
                case (m_mode)
                    0: begin
                        t_k = lookup(m_row, m_s2);
                        if (t_k >= 0) begin
                            m_key = t_k; m_pat = m_s2; m_n = 1; m_mode = 1;
                        end else m_row = (m_row + 1) % 4;
                    end
                    1: begin
                        if (m_s2 == m_pat) begin
                            m_n++;
                            if (m_n == DEB) begin t_push = 1'b1; m_mode = 2; end
                        end else begin
                            m_mode = 0; m_row = (m_row + 1) % 4;
                        end
                    end
                    2: if (m_s2 == 7) begin m_n = 1; m_mode = 3; end
                    3: begin
                        if (m_s2 == 7) begin
                            m_n++;
                            if (m_n == DEB) begin m_mode = 0; m_row = (m_row + 1) % 4; end
                        end else m_mode = 2;
                    end
                    default: m_mode = 0;
                endcase
            end
            if (t_pop) void'(m_q.pop_front());
            if (t_push) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_key);
                else t_set = 1'b1;
            end
            if (t_set) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
            m_div = t_tick ? 0 : m_div + 1;
            m_s2 = m_s1;
            m_s1 = int'(column);
        end
    end

    task automatic check_all();
        chk("sel", int'(sel), m_row);
        chk("valid", int'(kif.key_valid), (m_q.size() > 0) ? 1 : 0);
        chk("code", int'(kif.key_code), (m_q.size() > 0) ? m_q[0] : 15);
        chk("busy", int'(busy), (m_mode != 0) ? 1 : 0);
        chk("ovf", int'(overflow), m_ovf);
    endtask

    task automatic cyc();
        @(negedge clk);
        check_all();
        column = raw_en ? raw_col : pad(sel, keys);
    endtask

    task automatic wait_mode(input int target, input int budget);
        int n;
        n = 0;
        while (m_mode != target && n < budget) begin
            cyc();
            n++;
        end
        chk("wait_busy", int'(busy), (target != 0) ? 1 : 0);
    endtask

    task automatic press(input int digit);
        keys = '0;
        keys[(digit == 0) ? 10 : digit - 1] = 1'b1;
    endtask

    task automatic tap(input int digit);
        press(digit);
        wait_mode(2, 300);
        keys = '0;
        wait_mode(0, 300);
    endtask

    int exp6[4] = '{2, 3, 4, 9};
    int n;
    int kind;
    int dur;
    int rbias;

    initial begin
        kif.key_ready = 1'b0;
        repeat (3) cyc();
        reset = 1'b1;
        repeat (20) cyc();
        chk("idle_valid", int'(kif.key_valid), 0);

        // Key 5 on row 1, held with no consumer.
        press(5);
        wait_mode(2, 300);
        chk("k5_code", int'(kif.key_code), 5);
        chk("k5_sel", int'(sel), 1);
        repeat (24) cyc();
        chk("k5_norep", int'(kif.key_code), 5);
        keys = '0;
        wait_mode(0, 300);
        chk("k5_relsel", int'(sel), 2);

        // Asynchronous reset with a key queued.
        reset = 1'b0;
        #1;
        chk("rst_sel", int'(sel), 0);
        chk("rst_valid", int'(kif.key_valid), 0);
        chk("rst_code", int'(kif.key_code), 15);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovf", int'(overflow), 0);
        cyc();
        reset = 1'b1;
        repeat (20) cyc();

        // Bounce: single tick of key 3, then open.
        press(3);
        wait_mode(1, 300);
        keys = '0;
        wait_mode(0, 300);
        chk("bounce_valid", int'(kif.key_valid), 0);
        press(3);
        wait_mode(1, 300);
        reset = 1'b0;
        #1;
        chk("rst_deb_busy", int'(busy), 0);
        keys = '0;
        cyc();
        reset = 1'b1;
        repeat (20) cyc();
        chk("rst_deb_valid", int'(kif.key_valid), 0);

        // Invalid patterns: multi-column and row-3 blank key.
        raw_en  = 1'b1;
        raw_col = 3'b001;
        repeat (24) cyc();
        raw_en = 1'b0;
        keys = '0;
        keys[9] = 1'b1;
        repeat (40) cyc();
        keys = '0;
        chk("inv_valid", int'(kif.key_valid), 0);
        chk("inv_busy", int'(busy), 0);

        // Overflow: five keys into a four-deep FIFO.
        tap(1); tap(2); tap(3); tap(4); tap(7);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_head", int'(kif.key_code), 1);
        clr_ovf = 1'b1;
        cyc();
        clr_ovf = 1'b0;
        chk("ovf_clr", int'(overflow), 0);
        kif.key_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain", int'(kif.key_code), i);
            cyc();
        end
        kif.key_ready = 1'b0;
        chk("drain_valid", int'(kif.key_valid), 0);
        chk("drain_code", int'(kif.key_code), 15);

        // Push of 9 while full, popped in the same cycle.
        tap(1); tap(2); tap(3); tap(4);
        press(9);
        n = 0;
        while (m_mode != 2 && n < 300) begin
            kif.key_ready = push_next();
            cyc();
            n++;
        end
        kif.key_ready = 1'b0;
        chk("full_pp_ovf", int'(overflow), 0);
        keys = '0;
        wait_mode(0, 300);
        kif.key_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("pp_drain", int'(kif.key_code), exp6[i]);
            cyc();
        end
        kif.key_ready = 1'b0;
        chk("pp_empty", int'(kif.key_valid), 0);

        // Randomized segments.
        for (int seg = 0; seg < 160; seg++) begin
            kind  = $urandom_range(0, 9);
            dur   = $urandom_range(1, 30);
            rbias = $urandom_range(0, 3);
            raw_en = 1'b0;
            keys = '0;
            if (kind <= 5) begin
                keys[$urandom_range(0, 11)] = 1'b1;
            end else if (kind == 6) begin
                keys[$urandom_range(0, 11)] = 1'b1;
                keys[$urandom_range(0, 11)] = 1'b1;
            end else if (kind == 8) begin
                raw_en  = 1'b1;
                raw_col = 3'($urandom_range(0, 7));
            end else if (kind == 9) begin
                reset = 1'b0;
                cyc();
                reset = 1'b1;
            end
            for (int c = 0; c < dur; c++) begin
                kif.key_ready = ($urandom_range(0, 3) < rbias);
                clr_ovf = ($urandom_range(0, 19) == 0);
                cyc();
            end
        end
        raw_en = 1'b0;
        keys = '0;
        kif.key_ready = 1'b1;
        clr_ovf = 1'b0;
        repeat (60) cyc();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan controller for the 4-row × 3-column numeric keypad. It sequences the row-select lines, synchronizes and debounces the active-low column inputs, and locks onto a single key until that key is released. Each accepted key is pushed as a BCD code into a small FIFO with a valid/ready handshake. It replaces the free-running row counter plus sample-and-hold path, and feeds the LED/display decoders and any downstream key consumer.

## Interface
- SCAN_DIV, 8192: clk cycles per scan tick; legal range ≥ 4.
- DEB_TICKS, 4: consecutive identical tick samples needed to accept a press or a release; legal range ≥ 2.
- FIFO_DEPTH, 4: key FIFO entries; must be a power of 2.
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-low reset.
- column  in  3  raw keypad columns, active-low; asynchronous to clk.
- sel  out  3  row select; 0..3 = rows {1,2,3}, {4,5,6}, {7,8,9}, {-,0,-}.
- key_valid  out  1  FIFO non-empty.
- key_code  out  4  FIFO head, BCD 0..9; 4'b1111 when empty.
- key_ready  in  1  consumer accepts the head this cycle.
- clr_ovf  in  1  synchronous clear of overflow.
- busy  out  1  FSM is not in SCAN.
- overflow  out  1  sticky flag: a key was dropped because the FIFO was full.

## Operation
- **Column input:** 2-flop synchronizer; both flops reset to 3'b111. All decisions use the synchronized value (col_s).
- **Prescaler:** counts 0..SCAN_DIV-1 and wraps. tick is a 1-clk pulse when count == SCAN_DIV-1. The FSM changes only on tick cycles.
- **Decode of (sel, col_s):**
  - Rows 0–2: 011→first key, 101→second key, 110→third key of the row (codes 1–9).
  - Row 3: only 101→0.
  - Every other pattern is invalid, including multi-key patterns, 111, and row-3 patterns 011/110.
- **FSM states SCAN / DEBOUNCE / HELD / RELEASE** (all transitions on tick):
  - SCAN: a valid decode latches cand_code and cand_col, sets deb_cnt=1 and moves to DEBOUNCE; sel freezes. Otherwise sel advances 0→1→2→3→0.
  - DEBOUNCE: if col_s == cand_col, deb_cnt increments. When deb_cnt reaches DEB_TICKS, push cand_code and move to HELD. If col_s differs, return to SCAN and advance sel; nothing is pushed.
  - HELD: col_s == 111 sets rel_cnt=1 and moves to RELEASE. Otherwise stay; no repeat pushes.
  - RELEASE: col_s == 111 increments rel_cnt. When rel_cnt reaches DEB_TICKS, return to SCAN and advance sel. Any non-111 value returns to HELD.
- **FIFO:** first-word fall-through.
  - Pop when key_valid && key_ready.
  - Push while full with no pop in the same cycle: entry dropped, overflow set.
  - Push and pop in the same cycle while full: both succeed, no overflow.
  - Push into empty: key_valid rises the next cycle.
- **overflow:** clr_ovf clears it. If a set and a clear occur in the same cycle, set wins.
- **busy** = (state != SCAN).

## Timing
- **Reset values:** sel=0, key_valid=0, key_code=1111, busy=0, overflow=0, prescaler=0, state=SCAN, FIFO empty.
- Reset is asynchronous at any time, including mid-debounce or mid-release. It discards the candidate and all FIFO contents.
- sel updates on the clk edge at tick. The next sample of col_s happens SCAN_DIV clks later, so the 2-clk synchronizer latency is always covered.
- **Press latency:** the first valid tick plus (DEB_TICKS-1) further ticks. key_valid=1 one clk after the accepting tick edge.
- Pop takes effect on the clk edge. The next entry appears on key_code in the following cycle; back-to-back pops drain one entry per clk.
- key_code and key_valid change only on push or pop edges.

## Test plan
Run with SCAN_DIV=4, DEB_TICKS=3, FIFO_DEPTH=4.
1. Assert reset (low) mid-run → outputs go immediately to sel=0, key_valid=0, key_code=1111, busy=0, overflow=0. Release with column=111 → sel steps 0,1,2,3,0 every 4 clks; key_valid stays 0.
2. Drive column=101 while sel=1, held → sel stays 1, busy=1. key_valid=1 with key_code=0101 one clk after the 3rd tick. Hold key_ready=0: no repeat push. Set column=111 for 3 ticks → busy=0, sel continues at 2.
3. Bounce: column=110 at sel=0 for 1 tick, then 111 → no push, busy returns to 0, sel advances to 1. Assert reset mid-DEBOUNCE → state SCAN, nothing pushed.
4. Invalid patterns: column=001 at sel=0, then column=011 at sel=3 → both ignored, sel keeps cycling, key_valid=0.
5. Press keys 1,2,3,4,7 with key_ready=0 → FIFO holds 1,2,3,4 and overflow=1; key 7 is dropped. Pulse clr_ovf → overflow=0. Set key_ready=1 → codes 0001, 0010, 0011, 0100 on consecutive clks, then key_valid=0 and key_code=1111.
6. FIFO full with key_ready=1 in the same cycle as a push of key 9 → no overflow; 9 appears last in drain order.
